// File: rtl/fp32_cvt_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : fp32_cvt_pipe_if
// Description : Request/response handshake bundle for the int-to-float32
//               conversion stage. master = requester/consumer side,
//               slave = the conversion stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp32_cvt_pipe_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [63:0]      req_in;
  logic [1:0]       req_typeOp;
  logic [2:0]       req_rm;
  logic [TAG_W-1:0] req_tag;

  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [4:0]       resp_flags;
  logic             resp_illegal;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_in, req_typeOp, req_rm, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_flags, resp_illegal, resp_tag
  );

  modport slave (
    input  req_valid, req_in, req_typeOp, req_rm, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_flags, resp_illegal, resp_tag
  );
endinterface
`default_nettype wire

// File: rtl/fp32_cvt_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp32_cvt_pipe
// Description : Issue/retire stage for integer-to-float32 conversion. One
//               operand register stage (S1) feeds a combinational converter
//               whose results are buffered in an in-order circular queue.
//               Holds the sticky fflags register, updated on retirement.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_cvt_pipe #(
  parameter int TAG_W  = 5,
  parameter int QDEPTH = 2
) (
  input  wire logic       clk,
  input  wire logic       reset,
  fp32_cvt_pipe_if.slave  bus,
  input  wire logic [1:0] frm,
  input  wire logic       flush,
  input  wire logic       fflags_clr,
  output logic      [4:0] fflags
);

  localparam int               PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Integer to float32. Rounding: 0=nearest-even, 1=toward zero,
  // 2=toward -inf, 3=toward +inf. Result is {NX, float32}; only NX can
  // occur because every 64-bit integer is within float32 range.
  function automatic logic [32:0] any_to_float32(
    input logic [63:0] in,
    input logic [1:0]  type_op,
    input logic [1:0]  rm
  );
    logic        sign;
    logic [63:0] mag;
    logic [63:0] norm;
    logic [5:0]  msb;
    logic [7:0]  exp_field;
    logic [22:0] frac;
    logic        guard;
    logic        sticky;
    logic        inc;
    logic [30:0] body;
    logic [32:0] res;
    sign = 1'b0;
    mag  = 64'd0;
    case (type_op)
      2'd0: mag = {32'd0, in[31:0]};
      2'd1: begin
        sign = in[31];
        mag  = {32'd0, sign ? (~in[31:0] + 32'd1) : in[31:0]};
      end
      2'd2: mag = in;
      default: begin
        sign = in[63];
        mag  = sign ? (~in + 64'd1) : in;
      end
    endcase
    msb = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (mag[i]) msb = 6'(i);
    end
    norm      = mag << (6'd63 - msb);
    frac      = norm[62:40];
    guard     = norm[39];
    sticky    = |norm[38:0];
    exp_field = {2'b00, msb} + 8'd127;
    case (rm)
      2'd0:    inc = guard && (sticky || frac[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = sign && (guard || sticky);
      default: inc = !sign && (guard || sticky);
    endcase
    // A mantissa carry ripples into the exponent field, which is the
    // correct result for a round-up to the next power of two.
    body = {exp_field, frac} + {30'd0, inc};
    if (mag == 64'd0) res = 33'd0;
    else              res = {guard | sticky, sign, body};
    return res;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [63:0]      s1_in_q,    s1_in_d;
  logic [1:0]       s1_type_q,  s1_type_d;
  logic [1:0]       s1_rm_q,    s1_rm_d;
  logic             s1_ill_q,   s1_ill_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  logic [31:0]      q_data_q  [QDEPTH];
  logic [4:0]       q_flags_q [QDEPTH];
  logic             q_ill_q   [QDEPTH];
  logic [TAG_W-1:0] q_tag_q   [QDEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [4:0]       fflags_q, fflags_d;

  logic [32:0]      cvt_res;
  logic [31:0]      push_data;
  logic [4:0]       push_flags;
  logic [4:0]       head_flags;
  logic             head_valid;
  logic             pop;
  logic             push;
  logic             ready;
  logic             accept;

  // Handshake decode; a full queue can still take S1 when its head leaves.
  always_comb begin
    head_valid = (count_q != '0);
    pop        = head_valid && bus.resp_ready;
    push       = !flush && s1_valid_q && ((count_q != CNT_FULL) || pop);
    ready      = !flush && (!s1_valid_q || push);
    accept     = bus.req_valid && ready;
  end

  // Converter driven from S1; illegal rounding modes produce a zero entry.
  always_comb begin
    cvt_res    = any_to_float32(s1_in_q, s1_type_q, s1_rm_q);
    push_data  = s1_ill_q ? 32'd0 : cvt_res[31:0];
    push_flags = s1_ill_q ? 5'd0  : {4'd0, cvt_res[32]};
    head_flags = head_valid ? q_flags_q[rd_ptr_q] : 5'd0;
  end

  // S1 next state: capture on accept, drain on push, flush drops it.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_in_d    = s1_in_q;
    s1_type_d  = s1_type_q;
    s1_rm_d    = s1_rm_q;
    s1_ill_d   = s1_ill_q;
    s1_tag_d   = s1_tag_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
      s1_in_d    = bus.req_in;
      s1_type_d  = bus.req_typeOp;
      s1_tag_d   = bus.req_tag;
      // Dynamic mode is resolved here so a later frm change cannot
      // affect an operation already in flight.
      case (bus.req_rm)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          s1_rm_d  = bus.req_rm[1:0];
          s1_ill_d = 1'b0;
        end
        3'd7: begin
          s1_rm_d  = frm;
          s1_ill_d = 1'b0;
        end
        default: begin
          s1_rm_d  = 2'd0;
          s1_ill_d = 1'b1;
        end
      endcase
    end else if (push) begin
      s1_valid_d = 1'b0;
    end
  end

  // Queue pointers and occupancy; flush empties the queue outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Sticky flags: a retiring entry's flags survive a simultaneous clear.
  always_comb begin
    fflags_d = fflags_q;
    if (pop) begin
      fflags_d = fflags_clr ? head_flags : (fflags_q | head_flags);
    end else if (fflags_clr) begin
      fflags_d = 5'd0;
    end
  end

  // Control and S1 registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_in_q    <= 64'd0;
      s1_type_q  <= 2'd0;
      s1_rm_q    <= 2'd0;
      s1_ill_q   <= 1'b0;
      s1_tag_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fflags_q   <= 5'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_in_q    <= s1_in_d;
      s1_type_q  <= s1_type_d;
      s1_rm_q    <= s1_rm_d;
      s1_ill_q   <= s1_ill_d;
      s1_tag_q   <= s1_tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fflags_q   <= fflags_d;
    end
  end

  // Queue storage; only ever observed through the count-qualified head.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data_q[wr_ptr_q]  <= push_data;
      q_flags_q[wr_ptr_q] <= push_flags;
      q_ill_q[wr_ptr_q]   <= s1_ill_q;
      q_tag_q[wr_ptr_q]   <= s1_tag_q;
    end
  end

  assign bus.req_ready    = ready;
  assign bus.resp_valid   = head_valid;
  assign bus.resp_data    = head_valid ? q_data_q[rd_ptr_q] : 32'd0;
  assign bus.resp_flags   = head_flags;
  assign bus.resp_illegal = head_valid ? q_ill_q[rd_ptr_q] : 1'b0;
  assign bus.resp_tag     = head_valid ? q_tag_q[rd_ptr_q] : '0;
  assign fflags           = fflags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_cvt_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_cvt_pipe
// Description : Self-checking bench for fp32_cvt_pipe: vector table,
//               directed handshake/flag/flush sequences and a randomized
//               phase checked by an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_cvt_pipe;
  localparam int TAG_W  = 5;
  localparam int QDEPTH = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] frm = 2'd0;
  logic       flush = 1'b0;
  logic       fflags_clr = 1'b0;
  logic [4:0] fflags;

  fp32_cvt_pipe_if #(.TAG_W(TAG_W)) bus ();

  fp32_cvt_pipe #(.TAG_W(TAG_W), .QDEPTH(QDEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .frm        (frm),
    .flush      (flush),
    .fflags_clr (fflags_clr),
    .fflags     (fflags)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [31:0]      data;
    logic [4:0]       flags;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } resp_t;

  // Reference conversion from the value itself: find the power-of-two
  // bracket, divide, and round by comparing the remainder with half an ulp.
  function automatic logic [36:0] ref_cvt(input logic [63:0] in, input logic [1:0] t, input logic [1:0] rm);
    logic        neg;
    logic [63:0] m, q, r, half, sig;
    longint      v, tmp;
    int          e, sh;
    logic        nx, up;
    neg = 1'b0;
    m   = in;
    case (t)
      2'd0: m = {32'd0, in[31:0]};
      2'd1: begin v = longint'($signed(in[31:0])); neg = (v < 0); m = neg ? 64'(-v) : 64'(v); end
      2'd2: m = in;
      default: begin v = $signed(in); neg = (v < 0); m = neg ? 64'(-v) : 64'(v); end
    endcase
    if (m == 64'd0) return 37'd0;
    e = 63;
    while (!m[e]) e--;
    nx = 1'b0;
    up = 1'b0;
    if (e <= 23) begin
      sig = m << (23 - e);
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      r    = m - (q << sh);
      half = 64'd1 << (sh - 1);
      nx   = (r != 64'd0);
      case (rm)
        2'd0:    up = (r > half) || ((r == half) && q[0]);
        2'd1:    up = 1'b0;
        2'd2:    up = neg && nx;
        default: up = !neg && nx;
      endcase
      sig = q;
    end
    tmp = longint'(e + 126) * 64'sd8388608 + longint'(sig) + longint'(up);
    return {4'd0, nx, neg, tmp[30:0]};
  endfunction

  function automatic resp_t model(input logic [63:0] in, input logic [1:0] t, input logic [2:0] rm,
                                  input logic [1:0] f, input logic [TAG_W-1:0] tag);
    resp_t       r;
    logic [36:0] c;
    r.tag     = tag;
    r.illegal = (rm >= 3'd4) && (rm <= 3'd6);
    if (r.illegal) begin
      r.data  = 32'd0;
      r.flags = 5'd0;
    end else begin
      c       = ref_cvt(in, t, (rm == 3'd7) ? f : rm[1:0]);
      r.data  = c[31:0];
      r.flags = c[36:32];
    end
    return r;
  endfunction

  // Scoreboard: expected responses in accept order plus a sticky-flag model.
  resp_t      exp_q[$];
  logic [4:0] m_fflags = 5'd0;

  always @(negedge clk) begin
    resp_t e;
    if (reset) begin
      exp_q.delete();
      m_fflags = 5'd0;
    end else begin
      chk("fflags", {59'd0, fflags}, {59'd0, m_fflags});
      if (flush) chk("ready_in_flush", {63'd0, bus.req_ready}, 64'd0);
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: resp_valid=1 tag=%0h, required no response", bus.resp_tag);
        end else begin
          e = exp_q[0];
          chk("sb_data", {32'd0, bus.resp_data}, {32'd0, e.data});
          chk("sb_flags", {59'd0, bus.resp_flags}, {59'd0, e.flags});
          chk("sb_illegal", {63'd0, bus.resp_illegal}, {63'd0, e.illegal});
          chk("sb_tag", {59'd0, bus.resp_tag}, {59'd0, e.tag});
          if (bus.resp_ready) begin
            m_fflags = fflags_clr ? e.flags : (m_fflags | e.flags);
            void'(exp_q.pop_front());
          end
        end
      end
      if (!(bus.resp_valid && bus.resp_ready) && fflags_clr) m_fflags = 5'd0;
      if (flush) exp_q.delete();
      else if (bus.req_valid && bus.req_ready)
        exp_q.push_back(model(bus.req_in, bus.req_typeOp, bus.req_rm, frm, bus.req_tag));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [63:0] in, input logic [1:0] t, input logic [2:0] rm, input logic [TAG_W-1:0] tag);
    bus.req_in     = in;
    bus.req_typeOp = t;
    bus.req_rm     = rm;
    bus.req_tag    = tag;
  endtask

  task automatic send(input logic [63:0] in, input logic [1:0] t, input logic [2:0] rm, input logic [TAG_W-1:0] tag);
    int n;
    set_req(in, t, rm, tag);
    bus.req_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready && n < 50) begin step(); n++; end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: req_ready=0 after %0d cycles, required 1", n);
    end
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!bus.resp_valid && n < 50) begin step(); n++; end
    chk("resp_timeout", {63'd0, bus.resp_valid}, 64'd1);
  endtask

  task automatic pop_one();
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
  endtask

  task automatic clear_flags();
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
  endtask

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       rand_operand = v;
      1:       rand_operand = 64'($urandom_range(0, 255));
      2:       rand_operand = 64'd1 << $urandom_range(0, 63);
      default: rand_operand = v >> $urandom_range(0, 63);
    endcase
  endfunction

  typedef struct {
    logic [63:0] in;
    logic [1:0]  t;
    logic [2:0]  rm;
    logic [1:0]  frm;
    logic [31:0] data;
    logic [4:0]  flags;
    logic        ill;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 3'd0, 2'd0, 32'hBF800000, 5'h00, 1'b0};
    vec[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 3'd0, 2'd0, 32'h5F800000, 5'h01, 1'b0};
    vec[2]  = '{64'h0000_0000_0100_0001, 2'd0, 3'd0, 2'd0, 32'h4B800000, 5'h01, 1'b0};
    vec[3]  = '{64'h0000_0000_0100_0001, 2'd0, 3'd7, 2'd3, 32'h4B800001, 5'h01, 1'b0};
    vec[4]  = '{64'h0000_0000_0100_0001, 2'd0, 3'd5, 2'd0, 32'h00000000, 5'h00, 1'b1};
    vec[5]  = '{64'h0000_0000_0000_0000, 2'd3, 3'd0, 2'd0, 32'h00000000, 5'h00, 1'b0};
    vec[6]  = '{64'hDEAD_0000_0000_0001, 2'd0, 3'd0, 2'd0, 32'h3F800000, 5'h00, 1'b0};
    vec[7]  = '{64'h8000_0000_0000_0000, 2'd3, 3'd0, 2'd0, 32'hDF000000, 5'h00, 1'b0};
    vec[8]  = '{64'h0000_0000_0100_0001, 2'd0, 3'd1, 2'd0, 32'h4B800000, 5'h01, 1'b0};
    vec[9]  = '{64'h0000_0000_0100_0003, 2'd0, 3'd0, 2'd0, 32'h4B800002, 5'h01, 1'b0};
    vec[10] = '{64'h0000_0000_FEFF_FFFF, 2'd1, 3'd2, 2'd0, 32'hCB800001, 5'h01, 1'b0};
    vec[11] = '{64'h0000_0000_FEFF_FFFF, 2'd1, 3'd3, 2'd0, 32'hCB800000, 5'h01, 1'b0};
    vec[12] = '{64'h0000_0000_FFFF_FFFF, 2'd0, 3'd1, 2'd0, 32'h4F7FFFFF, 5'h01, 1'b0};
    vec[13] = '{64'h0000_0000_0100_0001, 2'd0, 3'd7, 2'd1, 32'h4B800000, 5'h01, 1'b0};
    vec[14] = '{64'h0000_0000_0000_0005, 2'd2, 3'd6, 2'd2, 32'h00000000, 5'h00, 1'b1};
    vec[15] = '{64'h7FFF_FFFF_FFFF_FFFF, 2'd3, 3'd3, 2'd0, 32'h5F000000, 5'h01, 1'b0};

    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    set_req(64'd0, 2'd0, 3'd0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_resp_data", {32'd0, bus.resp_data}, 64'd0);
    chk("rst_resp_flags", {59'd0, bus.resp_flags}, 64'd0);
    chk("rst_resp_illegal", {63'd0, bus.resp_illegal}, 64'd0);
    chk("rst_resp_tag", {59'd0, bus.resp_tag}, 64'd0);
    chk("rst_fflags", {59'd0, fflags}, 64'd0);
    reset = 1'b0;
    step();

    // Latency: accepted at E0, visible only after E1.
    send(64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 3'd0, 5'd3);
    chk("lat_e0_valid", {63'd0, bus.resp_valid}, 64'd0);
    step();
    chk("lat_e1_valid", {63'd0, bus.resp_valid}, 64'd1);
    chk("lat_data", {32'd0, bus.resp_data}, 64'hBF800000);
    chk("lat_tag", {59'd0, bus.resp_tag}, 64'd3);
    pop_one();
    chk("lat_fflags", {59'd0, fflags}, 64'd0);

    // Vector table, each in isolation with a cleared flag register.
    for (int i = 0; i < NV; i++) begin
      clear_flags();
      chk("tbl_clr", {59'd0, fflags}, 64'd0);
      frm = vec[i].frm;
      send(vec[i].in, vec[i].t, vec[i].rm, 5'(i + 3));
      frm = ~vec[i].frm;
      wait_resp();
      chk("tbl_data", {32'd0, bus.resp_data}, {32'd0, vec[i].data});
      chk("tbl_flags", {59'd0, bus.resp_flags}, {59'd0, vec[i].flags});
      chk("tbl_illegal", {63'd0, bus.resp_illegal}, {63'd0, vec[i].ill});
      chk("tbl_tag", {59'd0, bus.resp_tag}, 64'(i + 3));
      pop_one();
      chk("tbl_fflags", {59'd0, fflags}, {59'd0, vec[i].flags});
      chk("tbl_empty", {63'd0, bus.resp_valid}, 64'd0);
    end

    // Back-pressure: tags 1,2,3 fill queue and S1, then drain in order.
    bus.resp_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      set_req(64'(t), 2'd0, 3'd0, 5'(t));
      bus.req_valid = 1'b1;
      #1;
      chk("bp_ready_fill", {63'd0, bus.req_ready}, 64'd1);
      step();
    end
    bus.req_valid = 1'b0;
    #1;
    chk("bp_ready_full", {63'd0, bus.req_ready}, 64'd0);
    chk("bp_head", {59'd0, bus.resp_tag}, 64'd1);
    step();
    chk("bp_head_stable", {59'd0, bus.resp_tag}, 64'd1);
    chk("bp_data_stable", {32'd0, bus.resp_data}, 64'h3F800000);
    chk("bp_ready_held", {63'd0, bus.req_ready}, 64'd0);
    bus.resp_ready = 1'b1;
    step();
    chk("bp_ready_back", {63'd0, bus.req_ready}, 64'd1);
    chk("bp_order2", {59'd0, bus.resp_tag}, 64'd2);
    step();
    chk("bp_order3", {59'd0, bus.resp_tag}, 64'd3);
    step();
    chk("bp_drained", {63'd0, bus.resp_valid}, 64'd0);
    bus.resp_ready = 1'b0;

    // Clear together with pop keeps the retiring flags; clear alone zeroes.
    clear_flags();
    send(64'h0100_0001, 2'd0, 3'd0, 5'd7);
    wait_resp();
    pop_one();
    chk("clr_setup", {59'd0, fflags}, 64'd1);
    for (int t = 10; t <= 12; t++) begin
      set_req(64'h0100_0001, 2'd0, 3'd0, 5'(t));
      bus.req_valid = 1'b1;
      step();
    end
    bus.req_valid = 1'b0;
    #1;
    chk("clr_full", {63'd0, bus.req_ready}, 64'd0);
    bus.resp_ready = 1'b1;
    fflags_clr = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    fflags_clr = 1'b0;
    chk("clr_with_pop", {59'd0, fflags}, 64'd1);
    clear_flags();
    chk("clr_alone", {59'd0, fflags}, 64'd0);
    bus.resp_ready = 1'b1;
    repeat (3) step();
    bus.resp_ready = 1'b0;
    chk("clr_drained", {63'd0, bus.resp_valid}, 64'd0);
    chk("clr_reaccum", {59'd0, fflags}, 64'd1);
    send(64'd5, 2'd0, 3'd0, 5'd13);
    wait_resp();
    bus.resp_ready = 1'b1;
    fflags_clr = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    fflags_clr = 1'b0;
    chk("clr_pop_exact", {59'd0, fflags}, 64'd0);

    // Flush with two queued entries and S1 occupied.
    send(64'h0100_0001, 2'd0, 3'd0, 5'd8);
    wait_resp();
    pop_one();
    for (int t = 4; t <= 6; t++) begin
      set_req(64'(t), 2'd0, 3'd0, 5'(t));
      bus.req_valid = 1'b1;
      step();
    end
    bus.req_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("fl_ready_low", {63'd0, bus.req_ready}, 64'd0);
    step();
    flush = 1'b0;
    #1;
    chk("fl_empty", {63'd0, bus.resp_valid}, 64'd0);
    chk("fl_fflags", {59'd0, fflags}, 64'd1);
    chk("fl_ready", {63'd0, bus.req_ready}, 64'd1);
    step();
    chk("fl_s1_gone", {63'd0, bus.resp_valid}, 64'd0);
    send(64'd2, 2'd0, 3'd0, 5'd9);
    wait_resp();
    chk("fl_tag9", {59'd0, bus.resp_tag}, 64'd9);
    pop_one();
    chk("fl_only9", {63'd0, bus.resp_valid}, 64'd0);

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid  = ($urandom_range(0, 9) < 7);
      set_req(rand_operand(), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      frm            = 2'($urandom_range(0, 3));
      flush          = ($urandom_range(0, 49) == 0);
      fflags_clr     = ($urandom_range(0, 19) == 0);
      bus.resp_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    bus.req_valid  = 1'b0;
    flush          = 1'b0;
    fflags_clr     = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (6) step();
    bus.resp_ready = 1'b0;
    chk("rnd_drained", {63'd0, bus.resp_valid}, 64'd0);

    // Asynchronous reset with work in flight and sticky flags set.
    send(64'h0100_0001, 2'd0, 3'd0, 5'd1);
    wait_resp();
    pop_one();
    send(64'd3, 2'd0, 3'd0, 5'd2);
    wait_resp();
    chk("mid_pre_flags", {59'd0, fflags}, 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("mid_rst_fflags", {59'd0, fflags}, 64'd0);
    chk("mid_rst_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("mid_rst_tag", {59'd0, bus.resp_tag}, 64'd0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_valid", {63'd0, bus.resp_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
